// File: rtl/movement_control_pkg.sv
// Shared encodings for the movement controller and the movement datapath:
// datapath command codes, FSM states, bird mode flags and the direction LFSR.
package movement_control_pkg;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned LFSR_W = 8;

  // Datapath command codes carried on the control bus
  localparam logic [CTRL_W-1:0] CTRL_HOLD    = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_CLEAR   = 4'b0001;
  localparam logic [CTRL_W-1:0] CTRL_RIGHT   = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_LEFT    = 4'b0011;
  localparam logic [CTRL_W-1:0] CTRL_PREHOLD = 4'b0100;
  localparam logic [CTRL_W-1:0] CTRL_DRAW    = 4'b0101;
  localparam logic [CTRL_W-1:0] CTRL_DOWN    = 4'b0110;
  localparam logic [CTRL_W-1:0] CTRL_UP      = 4'b0111;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    ST_PREHOLD = 3'd0,
    ST_HOLD    = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_HMOVE   = 3'd3,
    ST_VMOVE   = 3'd4,
    ST_DRAW    = 3'd5
  } mc_state_e;

  typedef struct packed {
    logic fly;
    logic fall;
  } bird_mode_t;

  // Fibonacci LFSR, taps 8,6,5,4
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/movement_control_frame_tick.sv
// Free-running frame divider; tick_c is high for the one cycle on which the
// counter wraps from FRAME_DIV-1 back to 0.
module movement_control_frame_tick #(
  parameter int unsigned FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tick_c
);

  localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (run) begin
      if (cnt_q == CNT_LAST) cnt_q <= '0;
      else                   cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_c = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/movement_control.sv
// Frame sequencer for the player and the bird: per frame it clears, moves and
// redraws each object, and tracks the bird's normal / shot-fall / fly-away modes.
module movement_control
  import movement_control_pkg::*;
#(
  parameter int unsigned FRAME_DIV  = 833333,
  parameter int unsigned FLY_FRAMES = 600,
  parameter int unsigned DIR_FRAMES = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mv_left,
  input  logic              mv_right,
  input  logic              mv_up,
  input  logic              mv_down,
  input  logic              isShot,
  input  logic              enable,
  input  logic              leave,
  output logic [CTRL_W-1:0] control,
  output logic              PorB,
  output logic              fly,
  output logic              fall
);

  localparam int unsigned ESC_W = (FLY_FRAMES > 1) ? $clog2(FLY_FRAMES) : 1;
  localparam int unsigned DIR_W = (DIR_FRAMES > 1) ? $clog2(DIR_FRAMES) : 1;
  localparam logic [ESC_W-1:0] ESC_LAST = ESC_W'(FLY_FRAMES - 1);
  localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(DIR_FRAMES - 1);

  mc_state_e         state_q, state_d;
  logic [CTRL_W-1:0] control_d;
  logic [CTRL_W-1:0] h_code_c, v_code_c;
  logic              porb_d;
  logic              bird_done_c;
  logic              run_c, tick_c;

  bird_mode_t        mode_q;
  logic [ESC_W-1:0]  esc_q;
  logic [DIR_W-1:0]  dir_cnt_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_next_c;
  logic              dir_x_q, dir_y_q;

  assign run_c       = (state_q != ST_PREHOLD);
  assign lfsr_next_c = lfsr_step(lfsr_q);
  assign fly         = mode_q.fly;
  assign fall        = mode_q.fall;

  movement_control_frame_tick #(
    .FRAME_DIV (FRAME_DIV)
  ) u_frame_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run_c),
    .tick_c  (tick_c)
  );

  // Move commands for the object currently selected by PorB
  always_comb begin
    h_code_c = CTRL_HOLD;
    v_code_c = CTRL_HOLD;
    if (PorB) begin
      if (mode_q.fall) begin
        h_code_c = CTRL_HOLD;
        v_code_c = CTRL_DOWN;
      end else if (mode_q.fly) begin
        h_code_c = CTRL_HOLD;
        v_code_c = CTRL_UP;
      end else begin
        h_code_c = dir_x_q ? CTRL_RIGHT : CTRL_LEFT;
        v_code_c = dir_y_q ? CTRL_DOWN  : CTRL_UP;
      end
    end else begin
      if (mv_left)       h_code_c = CTRL_LEFT;
      else if (mv_right) h_code_c = CTRL_RIGHT;
      if (mv_up)         v_code_c = CTRL_UP;
      else if (mv_down)  v_code_c = CTRL_DOWN;
    end
  end

  // Next state; control is loaded with the code of the state being entered
  always_comb begin
    state_d     = state_q;
    control_d   = control;
    porb_d      = PorB;
    bird_done_c = 1'b0;
    case (state_q)
      ST_PREHOLD: begin
        if (start) begin
          state_d   = ST_HOLD;
          control_d = CTRL_HOLD;
        end
      end
      ST_HOLD: begin
        if (tick_c) begin
          state_d   = ST_CLEAR;
          control_d = CTRL_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (enable) begin
          state_d   = ST_HMOVE;
          control_d = h_code_c;
        end
      end
      ST_HMOVE: begin
        state_d   = ST_VMOVE;
        control_d = v_code_c;
      end
      ST_VMOVE: begin
        state_d   = ST_DRAW;
        control_d = CTRL_DRAW;
      end
      ST_DRAW: begin
        if (enable) begin
          if (PorB) begin
            state_d     = ST_HOLD;
            control_d   = CTRL_HOLD;
            porb_d      = 1'b0;
            bird_done_c = 1'b1;
          end else begin
            state_d   = ST_CLEAR;
            control_d = CTRL_CLEAR;
            porb_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_PREHOLD;
        control_d = CTRL_PREHOLD;
        porb_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PREHOLD;
      control <= CTRL_PREHOLD;
      PorB    <= 1'b0;
    end else begin
      state_q <= state_d;
      control <= control_d;
      PorB    <= porb_d;
    end
  end

  // Bird mode: leave beats isShot; a shot frame does not count toward fly-away
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= '0;
      esc_q  <= '0;
    end else if (leave) begin
      mode_q <= '0;
      esc_q  <= '0;
    end else if (isShot && !mode_q.fly && !mode_q.fall) begin
      mode_q.fall <= 1'b1;
    end else if (bird_done_c && !mode_q.fly && !mode_q.fall) begin
      if (esc_q == ESC_LAST) begin
        mode_q.fly <= 1'b1;
        esc_q      <= '0;
      end else begin
        esc_q <= esc_q + ESC_W'(1);
      end
    end
  end

  // Direction re-roll from the LFSR every DIR_FRAMES bird frames
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q    <= LFSR_SEED;
      dir_cnt_q <= '0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b0;
    end else if (bird_done_c) begin
      lfsr_q <= lfsr_next_c;
      if (dir_cnt_q == DIR_LAST) begin
        dir_cnt_q <= '0;
        dir_x_q   <= lfsr_next_c[0];
        dir_y_q   <= lfsr_next_c[1];
      end else begin
        dir_cnt_q <= dir_cnt_q + DIR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_movement_control.sv
// Scoreboard bench for movement_control: expected control/PorB sequences are
// queued per frame and matched against every change of the control bus.
module tb_movement_control;

  localparam int FRAME_DIV  = 16;
  localparam int FLY_FRAMES = 4;
  localparam int DIR_FRAMES = 2;

  localparam logic [3:0] C_HOLD    = 4'b0000;
  localparam logic [3:0] C_CLEAR   = 4'b0001;
  localparam logic [3:0] C_RIGHT   = 4'b0010;
  localparam logic [3:0] C_LEFT    = 4'b0011;
  localparam logic [3:0] C_PREHOLD = 4'b0100;
  localparam logic [3:0] C_DRAW    = 4'b0101;
  localparam logic [3:0] C_DOWN    = 4'b0110;
  localparam logic [3:0] C_UP      = 4'b0111;

  logic       clk, reset_n, start;
  logic       mv_left, mv_right, mv_up, mv_down;
  logic       isShot, enable, leave;
  logic [3:0] control;
  logic       PorB, fly, fall;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       porb;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic       sb_on;
  logic [3:0] prev_ctrl;
  int         n_vec = 0;
  int         n_err = 0;

  // reference model of the bird state
  logic [7:0] m_lfsr = 8'hA5;
  int         m_dir_cnt = 0;
  logic       m_dx = 1'b1, m_dy = 1'b0;
  int         m_esc = 0;
  logic       m_fly = 1'b0, m_fall = 1'b0;

  movement_control #(
    .FRAME_DIV  (FRAME_DIV),
    .FLY_FRAMES (FLY_FRAMES),
    .DIR_FRAMES (DIR_FRAMES)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .mv_left  (mv_left),
    .mv_right (mv_right),
    .mv_up    (mv_up),
    .mv_down  (mv_down),
    .isShot   (isShot),
    .enable   (enable),
    .leave    (leave),
    .control  (control),
    .PorB     (PorB),
    .fly      (fly),
    .fall     (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic p);
    exp_t e;
    e.ctrl = c;
    e.porb = p;
    sb_q.push_back(e);
  endtask

  task automatic wait_code(input logic [3:0] c, input string tag);
    int i;
    i = 0;
    while (control !== c && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(control), 32'(c));
  endtask

  // wait for state entry, hold it dly cycles, then pulse enable once
  task automatic pulse_en(input logic [3:0] c, input int dly);
    wait_code(c, "wait_entry");
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("hold_code", 32'(control), 32'(c));
    end
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic model_bird_done();
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    if (m_dir_cnt == DIR_FRAMES - 1) begin
      m_dir_cnt = 0;
      m_dx = m_lfsr[0];
      m_dy = m_lfsr[1];
    end else begin
      m_dir_cnt++;
    end
    if (!m_fly && !m_fall) begin
      if (m_esc == FLY_FRAMES - 1) begin
        m_fly = 1'b1;
        m_esc = 0;
      end else begin
        m_esc++;
      end
    end
  endtask

  task automatic bird_codes(output logic [3:0] bh, output logic [3:0] bv);
    if (m_fall) begin
      bh = C_HOLD; bv = C_DOWN;
    end else if (m_fly) begin
      bh = C_HOLD; bv = C_UP;
    end else begin
      bh = m_dx ? C_RIGHT : C_LEFT;
      bv = m_dy ? C_DOWN : C_UP;
    end
  endtask

  task automatic run_frame(input logic l, input logic r, input logic u, input logic d,
                           input int clr_dly);
    logic [3:0] ph, pv, bh, bv;
    mv_left = l; mv_right = r; mv_up = u; mv_down = d;
    ph = l ? C_LEFT : (r ? C_RIGHT : C_HOLD);
    pv = u ? C_UP : (d ? C_DOWN : C_HOLD);
    bird_codes(bh, bv);
    push(C_CLEAR, 1'b0); push(ph, 1'b0); push(pv, 1'b0); push(C_DRAW, 1'b0);
    push(C_CLEAR, 1'b1); push(bh, 1'b1); push(bv, 1'b1); push(C_DRAW, 1'b1);
    push(C_HOLD, 1'b0);
    pulse_en(C_CLEAR, clr_dly);
    pulse_en(C_DRAW, 3);
    pulse_en(C_CLEAR, 3);
    pulse_en(C_DRAW, 3);
    wait_code(C_HOLD, "frame_end");
    model_bird_done();
  endtask

  // scoreboard: every change of control must match the next queued entry
  always @(negedge clk) begin
    if (sb_on && control !== prev_ctrl) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_ctrl", 32'(control), 32'(mon_e.ctrl));
        chk("sb_porb", 32'(PorB), 32'(mon_e.porb));
      end
    end
    prev_ctrl = control;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; sb_on = 1'b0; prev_ctrl = C_PREHOLD;
    mv_left = 1'b0; mv_right = 1'b0; mv_up = 1'b0; mv_down = 1'b0;
    isShot = 1'b0; enable = 1'b0; leave = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'(control), 32'(C_PREHOLD));
    chk("rst_porb", 32'(PorB), 32'd0);
    chk("rst_fly", 32'(fly), 32'd0);
    chk("rst_fall", 32'(fall), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 25 == 24) begin
        chk("prehold_ctrl", 32'(control), 32'(C_PREHOLD));
        chk("prehold_porb", 32'(PorB), 32'd0);
      end
    end

    sb_on = 1'b1;
    push(C_HOLD, 1'b0);
    start = 1'b1;
    run_frame(1'b1, 1'b1, 1'b1, 1'b0, 3);
    run_frame(1'b0, 1'b1, 1'b0, 1'b1, 3);
    run_frame(1'b1, 1'b0, 1'b0, 1'b1, 40);

    // shot in HOLD
    @(negedge clk); isShot = 1'b1;
    @(negedge clk); isShot = 1'b0;
    chk("shot_fall", 32'(fall), 32'd1);
    chk("shot_fly", 32'(fly), 32'd0);
    m_fall = 1'b1;
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, 3);

    @(negedge clk); leave = 1'b1;
    @(negedge clk); leave = 1'b0;
    chk("leave_fall", 32'(fall), 32'd0);
    m_fall = 1'b0;
    m_esc = 0;

    for (int f = 0; f < FLY_FRAMES; f++) begin
      run_frame(1'b1, 1'b0, 1'b0, 1'b1, 3);
      chk("fly_track", 32'(fly), 32'(m_fly));
    end
    chk("fly_set", 32'(fly), 32'd1);
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, 3);

    @(negedge clk); isShot = 1'b1;
    @(negedge clk); isShot = 1'b0;
    chk("shot_ignored_fall", 32'(fall), 32'd0);
    chk("shot_ignored_fly", 32'(fly), 32'd1);

    @(negedge clk); leave = 1'b1; isShot = 1'b1;
    @(negedge clk); leave = 1'b0; isShot = 1'b0;
    chk("leave_shot_fly", 32'(fly), 32'd0);
    chk("leave_shot_fall", 32'(fall), 32'd0);
    m_fly = 1'b0;
    m_esc = 0;
    run_frame(1'b1, 1'b0, 1'b1, 1'b0, 3);

    // async reset during bird VMOVE while falling
    @(negedge clk); isShot = 1'b1;
    @(negedge clk); isShot = 1'b0;
    chk("shot2_fall", 32'(fall), 32'd1);
    m_fall = 1'b1;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    sb_on = 1'b0;
    pulse_en(C_CLEAR, 3);
    pulse_en(C_DRAW, 3);
    pulse_en(C_CLEAR, 3);
    @(posedge clk);
    #1;
    chk("bird_vmove", 32'(control), 32'(C_DOWN));
    chk("bird_vmove_porb", 32'(PorB), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_ctrl", 32'(control), 32'(C_PREHOLD));
    chk("async_porb", 32'(PorB), 32'd0);
    chk("async_fly", 32'(fly), 32'd0);
    chk("async_fall", 32'(fall), 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 10 == 9) chk("post_rst_ctrl", 32'(control), 32'(C_PREHOLD));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
